switch_debounce_4: RTL and testbench
====================================

Name: switch_debounce_4

Overview:
- Four-channel switch conditioner placed directly upstream of the board's switch-driven logic (bit counter, 7-segment path).
- Each raw push-button input is synchronised into i_Clk and debounced by a per-channel stability counter.
- Each channel outputs a clean level plus single-cycle rise and fall strobes, so downstream stages need no edge detectors of their own.

Parameters:
- DEBOUNCE_LIMIT, 250000, number of consecutive synchronised cycles a new level must persist before it is accepted (10 ms at 25 MHz); legal range 2..2^COUNT_WIDTH-1.
- COUNT_WIDTH, 18, width of each channel's stability counter.

Ports:
- i_Clk  in  1  system clock, all state on rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Switch_1..i_Switch_4  in  1 each  raw, asynchronous, bouncing switch inputs (1 = pressed).
- o_Switch_1..o_Switch_4  out  1 each  debounced level.
- o_Rise_1..o_Rise_4  out  1 each  one-cycle strobe on debounced 0->1.
- o_Fall_1..o_Fall_4  out  1 each  one-cycle strobe on debounced 1->0.

Behaviour:
- Reset: one clock; i_Reset_n is asynchronous and active-low.
  - While i_Reset_n = 0, all synchroniser flops, counters, o_Switch_N, o_Rise_N and o_Fall_N are 0, independent of the clock.
  - Reset deassertion is assumed synchronised externally.
- Channels are identical and fully independent. No shared state.
- Synchroniser: two flops per channel, sync1 <= i_Switch_N, sync2 <= sync1.
- Stability counter, per channel, evaluated each rising edge:
  - If sync2 == o_Switch_N: counter <= 0.
  - Else if counter == DEBOUNCE_LIMIT-1: o_Switch_N <= sync2 and counter <= 0.
  - Else: counter <= counter + 1.
- Counter overflow: the counter never exceeds DEBOUNCE_LIMIT-1, so it never wraps.
- Strobes:
  - o_Rise_N and o_Fall_N are registered.
  - o_Rise_N = 1 in exactly the cycle in which o_Switch_N first reads 1 after being 0; o_Fall_N likewise for 1->0.
  - Each strobe is 0 in all other cycles.
  - Rise and fall never assert together on one channel.
- Latency: raw input changes and then holds steady before rising edge E0. o_Switch_N and the matching strobe update on edge E0+DEBOUNCE_LIMIT+1, i.e. DEBOUNCE_LIMIT+2 edges counting E0.
- Glitch rejection: any excursion that lasts fewer than DEBOUNCE_LIMIT cycles at sync2 produces no output change. A single sync2 sample equal to o_Switch_N clears the counter, and the count restarts from 0.
- Startup: if a switch is held pressed through reset release, o_Switch_N rises after the full latency and o_Rise_N fires once. This is intended.
- Reset mid-count: counters are discarded immediately, outputs go to 0, and a full new latency applies after release.
- Simultaneous events: several channels changing on the same edge each update independently in the same cycle.

Test Plan:
(Bench uses DEBOUNCE_LIMIT=4, COUNT_WIDTH=3.)
- Reset and idle:
  - Stimulus: i_Reset_n=0 with all inputs 1, then hold reset for 3 cycles.
  - Response: all outputs 0 immediately, with no clock edge required.
  - Stimulus: release reset, all inputs 0 for 20 cycles.
  - Response: all outputs stay 0.
- Clean press and release:
  - Stimulus: i_Switch_1 goes 0->1 before edge E0 and is held.
  - Response: o_Switch_1=1 and o_Rise_1=1 after edge E0+5; o_Rise_1 returns to 0 after E0+6; channels 2-4 unchanged.
  - Stimulus: release before edge F0.
  - Response: o_Fall_1 pulses after F0+5.
- Bounce rejection:
  - Stimulus: i_Switch_2 pattern 1,1,1,0,1,1,0 (one value per cycle).
  - Response: o_Switch_2 stays 0 and there are no strobes.
  - Stimulus: then hold 1 from edge G0.
  - Response: o_Rise_2 occurs after G0+5 only.
- Simultaneous channels:
  - Stimulus: all four inputs rise before the same edge.
  - Response: all o_Switch_N and o_Rise_N assert in the same cycle, each rise strobe one cycle wide.
- Reset mid-operation:
  - Stimulus: i_Switch_3 held 1; drive i_Reset_n low 2 edges before the expected o_Switch_3 rise, then release before edge R0.
  - Response: o_Switch_3 stays 0, with no strobe, until after R0+5; then o_Rise_3 pulses exactly once.
- Held-at-startup:
  - Stimulus: i_Switch_4=1 throughout reset; release before edge R0.
  - Response: o_Switch_4 and o_Rise_4 assert after R0+5, with no o_Fall_4 pulse.

Source files
------------

// File: rtl/switch_debounce_4.sv
// Four-channel push-button conditioner: two-flop synchroniser, stability
// counter, and registered debounced level plus one-cycle rise/fall strobes.
module switch_debounce_4 #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned COUNT_WIDTH    = 18
) (
  input  logic i_Clk,
  input  logic i_Reset_n,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  input  logic i_Switch_3,
  input  logic i_Switch_4,
  output logic o_Switch_1,
  output logic o_Switch_2,
  output logic o_Switch_3,
  output logic o_Switch_4,
  output logic o_Rise_1,
  output logic o_Rise_2,
  output logic o_Rise_3,
  output logic o_Rise_4,
  output logic o_Fall_1,
  output logic o_Fall_2,
  output logic o_Fall_3,
  output logic o_Fall_4
);

  localparam int unsigned NUM_CH = 4;
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DEBOUNCE_LIMIT - 1);

  logic [NUM_CH-1:0]      w_raw;
  logic [NUM_CH-1:0]      r_sync1;
  logic [NUM_CH-1:0]      r_sync2;
  logic [NUM_CH-1:0]      r_level;
  logic [NUM_CH-1:0]      r_rise;
  logic [NUM_CH-1:0]      r_fall;
  logic [COUNT_WIDTH-1:0] r_count [NUM_CH];

  assign w_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  // Channels share only the clock and reset; each runs its own counter.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        r_count[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_rise  <= '0;
      r_fall  <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_count[i] <= '0;
        end else if (r_count[i] == LAST_COUNT) begin
          // New level has persisted long enough: accept it and strobe once.
          r_level[i] <= r_sync2[i];
          r_count[i] <= '0;
          r_rise[i]  <= r_sync2[i];
          r_fall[i]  <= ~r_sync2[i];
        end else begin
          r_count[i] <= r_count[i] + COUNT_WIDTH'(1);
        end
      end
    end
  end

  assign o_Switch_1 = r_level[0];
  assign o_Switch_2 = r_level[1];
  assign o_Switch_3 = r_level[2];
  assign o_Switch_4 = r_level[3];
  assign o_Rise_1   = r_rise[0];
  assign o_Rise_2   = r_rise[1];
  assign o_Rise_3   = r_rise[2];
  assign o_Rise_4   = r_rise[3];
  assign o_Fall_1   = r_fall[0];
  assign o_Fall_2   = r_fall[1];
  assign o_Fall_3   = r_fall[2];
  assign o_Fall_4   = r_fall[3];

endmodule

// File: tb/tb_switch_debounce_4.sv
// Bench for switch_debounce_4 (DEBOUNCE_LIMIT=4): directed scenarios plus
// randomized bouncing, compared against a sliding-window reference model.
module tb_switch_debounce_4;

  localparam int unsigned LIM = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_in;
  wire  [3:0] o_sw;
  wire  [3:0] o_rise;
  wire  [3:0] o_fall;

  int n_pass;
  int n_total;

  switch_debounce_4 #(.DEBOUNCE_LIMIT(LIM), .COUNT_WIDTH(3)) dut (
    .i_Clk      (clk),
    .i_Reset_n  (rst_n),
    .i_Switch_1 (sw_in[0]),
    .i_Switch_2 (sw_in[1]),
    .i_Switch_3 (sw_in[2]),
    .i_Switch_4 (sw_in[3]),
    .o_Switch_1 (o_sw[0]),
    .o_Switch_2 (o_sw[1]),
    .o_Switch_3 (o_sw[2]),
    .o_Switch_4 (o_sw[3]),
    .o_Rise_1   (o_rise[0]),
    .o_Rise_2   (o_rise[1]),
    .o_Rise_3   (o_rise[2]),
    .o_Rise_4   (o_rise[3]),
    .o_Fall_1   (o_fall[0]),
    .o_Fall_2   (o_fall[1]),
    .o_Fall_3   (o_fall[2]),
    .o_Fall_4   (o_fall[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: level flips at edge k when the raw values sampled at edges
  // k-LIM-1 .. k-2 all equal the opposite of the current level.
  logic [LIM+1:0] m_hist [4];
  logic [3:0]     m_sw;
  logic [3:0]     m_rise;
  logic [3:0]     m_fall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sw   = '0;
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < 4; c++) m_hist[c] = '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        m_hist[c] = {m_hist[c][LIM:0], sw_in[c]};
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        if (!m_sw[c] && m_hist[c][LIM+1:2] == {LIM{1'b1}}) begin
          m_sw[c]   = 1'b1;
          m_rise[c] = 1'b1;
        end else if (m_sw[c] && m_hist[c][LIM+1:2] == {LIM{1'b0}}) begin
          m_sw[c]   = 1'b0;
          m_fall[c] = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw_in = 4'hF;
    #1;
    n_total++;
    if ({o_sw, o_rise, o_fall} !== 12'h000)
      $display("FAIL reset_async: got %h want 000", {o_sw, o_rise, o_fall});
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if ({o_sw, o_rise, o_fall} !== 12'h000)
        $display("FAIL reset_hold[%0d]: got %h want 000", i, {o_sw, o_rise, o_fall});
      else n_pass++;
    end
    sw_in = 4'h0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_total++;
      if ({o_sw, o_rise, o_fall} !== 12'h000 || {m_sw, m_rise, m_fall} !== 12'h000)
        $display("FAIL idle[%0d]: got %h want 000", i, {o_sw, o_rise, o_fall});
      else n_pass++;
    end
  endtask

  task automatic test_press_release();
    sw_in[0] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      n_total++;
      if ({o_sw, o_rise, o_fall} !== {m_sw, m_rise, m_fall})
        $display("FAIL press_model[%0d]: got %h want %h", n, {o_sw, o_rise, o_fall}, {m_sw, m_rise, m_fall});
      else n_pass++;
      if (n == 5 || n == 6 || n == 7) begin
        n_total++;
        if ({o_sw, o_rise} !== ((n == 5) ? 8'h00 : (n == 6) ? 8'h11 : 8'h10))
          $display("FAIL press_edge[%0d]: got sw=%h rise=%h", n, o_sw, o_rise);
        else n_pass++;
      end
    end
    sw_in[0] = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      n_total++;
      if ({o_sw, o_rise, o_fall} !== {m_sw, m_rise, m_fall})
        $display("FAIL release_model[%0d]: got %h want %h", n, {o_sw, o_rise, o_fall}, {m_sw, m_rise, m_fall});
      else n_pass++;
      if (n == 6) begin
        n_total++;
        if (o_fall !== 4'h1 || o_sw !== 4'h0)
          $display("FAIL release_fall: got fall=%h sw=%h want 1/0", o_fall, o_sw);
        else n_pass++;
      end
    end
  endtask

  task automatic test_bounce();
    logic [6:0] pat;
    pat = 7'b0110111;
    for (int n = 0; n < 7; n++) begin
      sw_in[1] = pat[n];
      step();
      n_total++;
      if (o_sw[1] !== 1'b0 || o_rise[1] !== 1'b0 || o_fall[1] !== 1'b0 ||
          {o_sw, o_rise, o_fall} !== {m_sw, m_rise, m_fall})
        $display("FAIL bounce[%0d]: got %h want %h", n, {o_sw, o_rise, o_fall}, {m_sw, m_rise, m_fall});
      else n_pass++;
    end
    sw_in[1] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      n_total++;
      if (o_rise[1] !== ((n == 6) ? 1'b1 : 1'b0) || o_sw[1] !== ((n >= 6) ? 1'b1 : 1'b0))
        $display("FAIL bounce_hold[%0d]: got sw=%b rise=%b", n, o_sw[1], o_rise[1]);
      else n_pass++;
    end
    sw_in = 4'h0;
    for (int n = 0; n < 8; n++) step();
    n_total++;
    if ({o_sw, o_rise, o_fall} !== 12'h000)
      $display("FAIL bounce_settle: got %h want 000", {o_sw, o_rise, o_fall});
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    sw_in = 4'hF;
    for (int n = 1; n <= 8; n++) begin
      step();
      n_total++;
      if (o_rise !== ((n == 6) ? 4'hF : 4'h0) || o_sw !== ((n >= 6) ? 4'hF : 4'h0))
        $display("FAIL simul[%0d]: got sw=%h rise=%h", n, o_sw, o_rise);
      else n_pass++;
    end
    sw_in = 4'h0;
    for (int n = 1; n <= 8; n++) begin
      step();
      n_total++;
      if (o_fall !== ((n == 6) ? 4'hF : 4'h0) || o_sw !== ((n >= 6) ? 4'h0 : 4'hF))
        $display("FAIL simul_fall[%0d]: got sw=%h fall=%h", n, o_sw, o_fall);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int rises;
    sw_in[2] = 1'b1;
    for (int n = 1; n <= 4; n++) step();
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({o_sw, o_rise, o_fall} !== 12'h000)
      $display("FAIL midreset_async: got %h want 000", {o_sw, o_rise, o_fall});
    else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    rises = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (o_rise[2] === 1'b1) rises++;
      n_total++;
      if (o_sw[2] !== ((n >= 6) ? 1'b1 : 1'b0) || o_rise[2] !== ((n == 6) ? 1'b1 : 1'b0))
        $display("FAIL midreset[%0d]: got sw=%b rise=%b", n, o_sw[2], o_rise[2]);
      else n_pass++;
    end
    n_total++;
    if (rises !== 1)
      $display("FAIL midreset_rise_count: got %0d want 1", rises);
    else n_pass++;
  endtask

  task automatic test_startup_held();
    int falls;
    rst_n = 1'b0;
    sw_in = 4'b1000;
    step();
    step();
    rst_n = 1'b1;
    falls = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (o_fall[3] === 1'b1) falls++;
      n_total++;
      if (o_sw[3] !== ((n >= 6) ? 1'b1 : 1'b0) || o_rise[3] !== ((n == 6) ? 1'b1 : 1'b0) ||
          {o_sw, o_rise, o_fall} !== {m_sw, m_rise, m_fall})
        $display("FAIL startup[%0d]: got %h want %h", n, {o_sw, o_rise, o_fall}, {m_sw, m_rise, m_fall});
      else n_pass++;
    end
    n_total++;
    if (falls !== 0)
      $display("FAIL startup_fall_count: got %0d want 0", falls);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] target;
    target = sw_in;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 11) == 0) target[c] = ~target[c];
        sw_in[c] = ($urandom_range(0, 3) == 0) ? ~target[c] : target[c];
      end
      step();
      n_total++;
      if ({o_sw, o_rise, o_fall} !== {m_sw, m_rise, m_fall})
        $display("FAIL random[%0d]: got %h want %h", n, {o_sw, o_rise, o_fall}, {m_sw, m_rise, m_fall});
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    sw_in   = 4'h0;
    @(negedge clk);
    test_reset();
    test_press_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_startup_held();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
